pulse_meas_scheduler: RTL

Round-robin scheduler that shares one pulse-width measurement unit (idle/counting/done FSM, rising-edge start, 20-bit cycle count, done_tick) among N_CH pulse sources.
- Grants one requester at a time and gates that channel's pulse into the unit.
- Enforces a measurement timeout.
- Returns a tagged result (channel, cycles, timeout flag) per granted request.
- Sits between the sensor inputs and the shared counter, in front of the display/readout logic.

---
 rtl/pulse_meas_scheduler.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pulse_meas_scheduler.sv
// pulse_meas_scheduler
// Round-robin front end for one shared pulse-width measurement unit. One
// requesting channel is granted at a time. Its synchronised pulse is gated
// into the unit, and a tagged result is returned per grant. A measurement
// that runs too long is aborted and reported as a timeout.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req             per-channel measurement request (level)
//   pulse_in        per-channel synchronised pulse
//   grant           one-hot current grant, 0 when idle
//   busy            high whenever a grant is active
//   unit_pulse      gated pulse towards the shared unit
//   unit_read_time  measurement-window strobe towards the shared unit
//   unit_ready      shared unit is idle
//   unit_done_tick  shared unit completion strobe
//   unit_count      shared unit cycle count, valid with unit_done_tick
//   res_valid       one-cycle result strobe
//   res_ch          channel of the result
//   res_cycles      measured width in clk cycles, 0 on timeout
//   res_timeout     result was aborted by timeout
module pulse_meas_scheduler #(
  parameter int N_CH        = 4,
  parameter int CH_W        = 2,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] pulse_in,
  output logic [N_CH-1:0] grant,
  output logic            busy,
  output logic            unit_pulse,
  output logic            unit_read_time,
  input  logic            unit_ready,
  input  logic            unit_done_tick,
  input  logic [19:0]     unit_count,
  output logic            res_valid,
  output logic [CH_W-1:0] res_ch,
  output logic [19:0]     res_cycles,
  output logic            res_timeout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_MEASURE = 3'd2,
    S_DRAIN   = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_MAX   = '1;
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0] ONE_HOT0 = N_CH'(1);

  state_t          state, state_nxt;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] sel;
  logic [CH_W-1:0] pick_idx;
  logic [CH_W-1:0] scan_idx;
  logic [CH_W:0]   scan_sum;
  logic            pick_found;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;

  // First requesting channel at or above rr_ptr, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    scan_idx   = '0;
    for (int i = 0; i < N_CH; i++) begin
      scan_sum = {1'b0, rr_ptr} + (CH_W+1)'(i);
      if (scan_sum >= (CH_W+1)'(N_CH)) begin
        scan_sum = scan_sum - (CH_W+1)'(N_CH);
      end
      scan_idx = scan_sum[CH_W-1:0];
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign to_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    unit_pulse     = 1'b0;
    unit_read_time = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) state_nxt = S_ARM;
      end
      // Only start once the granted pulse is low, so the unit sees a clean
      // rising edge rather than joining a pulse already in progress.
      S_ARM: begin
        if (unit_ready && !pulse_in[sel]) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        unit_pulse     = pulse_in[sel];
        unit_read_time = 1'b1;
        if (unit_done_tick) begin
          state_nxt = S_REPORT;
        end else if (to_hit) begin
          state_nxt = S_DRAIN;
        end
      end
      // Pulse held low so a unit still counting finishes; its result is dropped.
      S_DRAIN: begin
        if (unit_ready) state_nxt = S_REPORT;
      end
      S_REPORT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      sel         <= '0;
      grant       <= '0;
      to_cnt      <= '0;
      res_ch      <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant <= ONE_HOT0 << pick_idx;
            sel   <= pick_idx;
          end
        end
        S_ARM: begin
          if (state_nxt == S_MEASURE) to_cnt <= '0;
        end
        S_MEASURE: begin
          if (to_cnt != TO_MAX) to_cnt <= to_cnt + 1'b1;
          if (unit_done_tick) begin
            res_ch      <= sel;
            res_cycles  <= unit_count;
            res_timeout <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (unit_ready) begin
            res_ch      <= sel;
            res_cycles  <= '0;
            res_timeout <= 1'b1;
          end
        end
        S_REPORT: begin
          grant  <= '0;
          rr_ptr <= (sel == CH_LAST) ? '0 : sel + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_REPORT);

endmodule
